layer_scheduler: RTL and testbench

- Top-level sequencer for the inference datapath. Launches NUM_LAYERS layer engines (conv, max-pool, fc) one at a time, in a fixed order, using their start/finish handshakes.
- Engines share one dual-port activation SRAM and one weight SRAM. The scheduler muxes the active engine's SRAM control onto the shared ports.
- Supplies each engine's act_offset from a per-layer table.
- Reports overall completion and protocol errors to the host/testbench.

---
 rtl/layer_sched_pkg.sv | 18 +
 rtl/sram_port_mux.sv | 16 +
 rtl/layer_scheduler.sv | 178 +++++++++++++++++
 tb/tb_layer_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sched_pkg.sv
// Shared constants for the layer scheduler: FSM state encoding and default widths.
package layer_sched_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_NUM_LAYERS  = 4;
    localparam int DEF_AW          = 16;
    localparam int DEF_DW          = 32;
    localparam int IDX_W           = $clog2(DEF_NUM_LAYERS);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/sram_port_mux.sv
// N:1 slice selector for a packed per-engine bus, forced to an idle value when inactive.
module sram_port_mux #(
    parameter int            N        = 4,
    parameter int            W        = 1,
    parameter logic [W-1:0]  IDLE_VAL = '0,
    parameter int            SW       = $clog2(N)
) (
    input  logic [N*W-1:0] bus,
    input  logic [SW-1:0]  sel,
    input  logic           active,
    output logic [W-1:0]   y
);

    assign y = active ? bus[sel*W +: W] : IDLE_VAL;

endmodule

// File: rtl/layer_scheduler.sv
// Sequences the layer engines one at a time and muxes the active engine onto the shared SRAMs.
// Optional cycle counter for the last completed layer: define LAYER_SCHEDULER_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start; idx holds its last value
// LAUNCH | one-cycle eng_start pulse to engine idx, bus granted
// RUN    | engine idx owns the shared SRAM ports until it finishes
// GAP    | ports idle for one cycle so the read pipeline drains
// DONE   | one-cycle done pulse
module layer_scheduler
    import layer_sched_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    // layer 0 sits in the least-significant slice
    parameter logic [NUM_LAYERS*AW-1:0] LAYER_OFFSETS = {16'd3072, 16'd2048, 16'd1024, 16'd0}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
    output logic                     protocol_err,
    output logic [AW-1:0]            act_offset,
    output logic [NUM_LAYERS-1:0]    eng_start,
    input  logic [NUM_LAYERS-1:0]    eng_finish,
    input  logic [NUM_LAYERS-1:0]    eng_act_cen,
    input  logic [NUM_LAYERS*4-1:0]  eng_act_wea0,
    input  logic [NUM_LAYERS*4-1:0]  eng_act_wea1,
    input  logic [NUM_LAYERS*AW-1:0] eng_act_addr0,
    input  logic [NUM_LAYERS*AW-1:0] eng_act_addr1,
    input  logic [NUM_LAYERS*DW-1:0] eng_act_wdata0,
    input  logic [NUM_LAYERS*DW-1:0] eng_act_wdata1,
    input  logic [NUM_LAYERS-1:0]    eng_weight_cen,
    input  logic [NUM_LAYERS*AW-1:0] eng_weight_addr0,
    input  logic [NUM_LAYERS*AW-1:0] eng_weight_addr1,
    output logic                     act_cen,
    output logic [3:0]               act_wea0,
    output logic [3:0]               act_wea1,
    output logic [AW-1:0]            act_addr0,
    output logic [AW-1:0]            act_addr1,
    output logic [DW-1:0]            act_wdata0,
    output logic [DW-1:0]            act_wdata1,
    output logic                     weight_cen,
    output logic [AW-1:0]            weight_addr0,
    output logic [AW-1:0]            weight_addr1,
    output logic [31:0]              last_layer_cycles
);

    localparam int IW    = $clog2(NUM_LAYERS);
    localparam int ACT_W = 1 + 8 + 2*AW + 2*DW;
    localparam int WGT_W = 1 + 2*AW;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_LAYERS-1);
    localparam logic [ACT_W-1:0] ACT_IDLE = {1'b1, {(ACT_W-1){1'b0}}};
    localparam logic [WGT_W-1:0] WGT_IDLE = {1'b1, {(WGT_W-1){1'b0}}};

    state_t                  state, state_nx;
    logic [IW-1:0]           idx;
    logic [NUM_LAYERS-1:0]   idx_onehot;
    logic                    stray_finish;
    logic                    accept_start;
    logic                    mux_active;

    assign idx_onehot   = NUM_LAYERS'(1) << idx;
    assign accept_start = (state == S_IDLE) && start;
    assign stray_finish = (|(eng_finish & ~idx_onehot)) ||
                          (eng_finish[idx] && (state != S_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept_start)
                idx <= '0;
            else if (state == S_GAP && idx != LAST_IDX)
                idx <= idx + 1'b1;
            if (accept_start)
                protocol_err <= 1'b0;
            else if (stray_finish)
                protocol_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_RUN;
            S_RUN:    if (eng_finish[idx]) state_nx = S_GAP;
            S_GAP:    state_nx = (idx == LAST_IDX) ? S_DONE : S_LAUNCH;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        eng_start  = '0;
        done       = 1'b0;
        busy       = 1'b1;
        mux_active = 1'b0;
        case (state)
            S_IDLE:   busy = 1'b0;
            S_LAUNCH: begin
                eng_start  = idx_onehot;
                mux_active = 1'b1;
            end
            S_RUN:    mux_active = 1'b1;
            S_DONE:   done = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

    assign cur_layer  = idx;
    assign act_offset = LAYER_OFFSETS[idx*AW +: AW];

    logic [NUM_LAYERS*ACT_W-1:0] act_bus;
    logic [NUM_LAYERS*WGT_W-1:0] wgt_bus;
    logic [ACT_W-1:0]            act_sel;
    logic [WGT_W-1:0]            wgt_sel;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pack
        assign act_bus[g*ACT_W +: ACT_W] = {eng_act_cen[g],
                                            eng_act_wea0[g*4 +: 4], eng_act_wea1[g*4 +: 4],
                                            eng_act_addr0[g*AW +: AW], eng_act_addr1[g*AW +: AW],
                                            eng_act_wdata0[g*DW +: DW], eng_act_wdata1[g*DW +: DW]};
        assign wgt_bus[g*WGT_W +: WGT_W] = {eng_weight_cen[g],
                                            eng_weight_addr0[g*AW +: AW], eng_weight_addr1[g*AW +: AW]};
    end

    sram_port_mux #(.N(NUM_LAYERS), .W(ACT_W), .IDLE_VAL(ACT_IDLE), .SW(IW)) u_act_mux (
        .bus    (act_bus),
        .sel    (idx),
        .active (mux_active),
        .y      (act_sel)
    );

    sram_port_mux #(.N(NUM_LAYERS), .W(WGT_W), .IDLE_VAL(WGT_IDLE), .SW(IW)) u_wgt_mux (
        .bus    (wgt_bus),
        .sel    (idx),
        .active (mux_active),
        .y      (wgt_sel)
    );

    assign {act_cen, act_wea0, act_wea1, act_addr0, act_addr1, act_wdata0, act_wdata1} = act_sel;
    assign {weight_cen, weight_addr0, weight_addr1} = wgt_sel;

`ifdef LAYER_SCHEDULER_PERF_CNT_EN
    logic [31:0] run_cnt;
    logic [31:0] run_cnt_inc;
    logic [31:0] last_q;

    assign run_cnt_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    // count includes the cycle in which the finish pulse arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
            last_q  <= '0;
        end else if (state == S_LAUNCH) begin
            run_cnt <= '0;
        end else if (state == S_RUN) begin
            run_cnt <= run_cnt_inc;
            if (eng_finish[idx])
                last_q <= run_cnt_inc;
        end
    end

    assign last_layer_cycles = last_q;
`else
    assign last_layer_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: timeline-based reference model plus directed literal checks.
module tb_layer_scheduler;
    import layer_sched_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int PH_LAUNCH = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_GAP    = 2;
    localparam int PH_DONE   = 3;
    localparam int PH_IDLE   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done, busy, protocol_err;
    logic [IDX_W-1:0] cur_layer;
    logic [AW-1:0] act_offset;
    logic [N-1:0] eng_start;
    logic [N-1:0] eng_finish = '0;
    logic [N-1:0] eng_act_cen = '1;
    logic [N*4-1:0] eng_act_wea0 = '0, eng_act_wea1 = '0;
    logic [N*AW-1:0] eng_act_addr0 = '0, eng_act_addr1 = '0;
    logic [N*DW-1:0] eng_act_wdata0 = '0, eng_act_wdata1 = '0;
    logic [N-1:0] eng_weight_cen = '1;
    logic [N*AW-1:0] eng_weight_addr0 = '0, eng_weight_addr1 = '0;
    logic act_cen, weight_cen;
    logic [3:0] act_wea0, act_wea1;
    logic [AW-1:0] act_addr0, act_addr1, weight_addr0, weight_addr1;
    logic [DW-1:0] act_wdata0, act_wdata1;
    logic [31:0] last_layer_cycles;

    always #5 clk = ~clk;

    layer_scheduler #(.NUM_LAYERS(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .cur_layer(cur_layer), .protocol_err(protocol_err), .act_offset(act_offset),
        .eng_start(eng_start), .eng_finish(eng_finish), .eng_act_cen(eng_act_cen),
        .eng_act_wea0(eng_act_wea0), .eng_act_wea1(eng_act_wea1),
        .eng_act_addr0(eng_act_addr0), .eng_act_addr1(eng_act_addr1),
        .eng_act_wdata0(eng_act_wdata0), .eng_act_wdata1(eng_act_wdata1),
        .eng_weight_cen(eng_weight_cen), .eng_weight_addr0(eng_weight_addr0),
        .eng_weight_addr1(eng_weight_addr1), .act_cen(act_cen), .act_wea0(act_wea0),
        .act_wea1(act_wea1), .act_addr0(act_addr0), .act_addr1(act_addr1),
        .act_wdata0(act_wdata0), .act_wdata1(act_wdata1), .weight_cen(weight_cen),
        .weight_addr0(weight_addr0), .weight_addr1(weight_addr1),
        .last_layer_cycles(last_layer_cycles)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model: a run is a timeline of (launch, r run cycles, gap) per layer, then done
    bit          m_busy = 0;
    int          m_k = 0;
    int          m_r[N] = '{1, 1, 1, 1};
    int          m_idx = 0;
    bit          m_err = 0;
    logic [31:0] m_last = '0;
    int          nom_r[N] = '{5, 10, 3, 7};

    bit d_rst = 0, d_start = 0, pin_eng1 = 0, random_mode = 0, use_nominal = 1;
    logic [N-1:0] d_stray = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void decode(output int layer, output int ph, output bit fin_now);
        int pos;
        layer = m_idx;
        ph = PH_IDLE;
        fin_now = 0;
        if (!m_busy) return;
        pos = m_k - 1;
        for (int i = 0; i < N; i++) begin
            if (pos < m_r[i] + 2) begin
                layer = i;
                fin_now = (pos == m_r[i]);
                ph = (pos == 0) ? PH_LAUNCH : (pos <= m_r[i]) ? PH_RUN : PH_GAP;
                return;
            end
            pos -= m_r[i] + 2;
        end
        layer = N - 1;
        ph = PH_DONE;
    endfunction

    task automatic drive_buses();
        for (int i = 0; i < N; i++) begin
            eng_act_wea0[i*4 +: 4]       = 4'($urandom);
            eng_act_wea1[i*4 +: 4]       = 4'($urandom);
            eng_act_addr0[i*AW +: AW]    = AW'($urandom);
            eng_act_addr1[i*AW +: AW]    = AW'($urandom);
            eng_act_wdata0[i*DW +: DW]   = $urandom;
            eng_act_wdata1[i*DW +: DW]   = $urandom;
            eng_weight_addr0[i*AW +: AW] = AW'($urandom);
            eng_weight_addr1[i*AW +: AW] = AW'($urandom);
        end
        eng_act_cen    = N'($urandom);
        eng_weight_cen = N'($urandom);
    endtask

    task automatic step();
        int layer, ph;
        bit fin_now, mux;
        logic [N-1:0] fin, stray;
        @(negedge clk);
        cyc++;
        decode(layer, ph, fin_now);
        drive_buses();
        if (pin_eng1) begin
            eng_act_addr0[AW +: AW] = 16'h0400;
            eng_act_wea0[4 +: 4]    = 4'hF;
        end
        if (random_mode) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 29) == 0);
        end else begin
            rst   = d_rst;
            start = d_start;
        end
        fin = '0;
        if (fin_now) fin[layer] = 1'b1;
        stray = d_stray;
        if (random_mode && $urandom_range(0, 24) == 0) stray[$urandom_range(0, N-1)] = 1'b1;
        if (ph == PH_RUN) stray[layer] = 1'b0;
        if (ph == PH_IDLE && start) stray = '0;
        eng_finish = fin | stray;
        #1;
        mux = (ph == PH_LAUNCH || ph == PH_RUN);
        chk("done", done, ph == PH_DONE);
        chk("busy", busy, ph != PH_IDLE);
        chk("cur_layer", cur_layer, layer);
        chk("act_offset", act_offset, 64'(layer * 1024));
        chk("eng_start", eng_start, (ph == PH_LAUNCH) ? (64'd1 << layer) : 64'd0);
        chk("protocol_err", protocol_err, m_err);
        chk("last_layer_cycles", last_layer_cycles, m_last);
        chk("act_cen", act_cen, mux ? eng_act_cen[layer] : 1'b1);
        chk("act_wea0", act_wea0, mux ? eng_act_wea0[layer*4 +: 4] : 4'h0);
        chk("act_wea1", act_wea1, mux ? eng_act_wea1[layer*4 +: 4] : 4'h0);
        chk("act_addr0", act_addr0, mux ? eng_act_addr0[layer*AW +: AW] : 16'h0);
        chk("act_addr1", act_addr1, mux ? eng_act_addr1[layer*AW +: AW] : 16'h0);
        chk("act_wdata0", act_wdata0, mux ? eng_act_wdata0[layer*DW +: DW] : 32'h0);
        chk("act_wdata1", act_wdata1, mux ? eng_act_wdata1[layer*DW +: DW] : 32'h0);
        chk("weight_cen", weight_cen, mux ? eng_weight_cen[layer] : 1'b1);
        chk("weight_addr0", weight_addr0, mux ? eng_weight_addr0[layer*AW +: AW] : 16'h0);
        chk("weight_addr1", weight_addr1, mux ? eng_weight_addr1[layer*AW +: AW] : 16'h0);
        // advance the model across the coming rising edge
        if (rst) begin
            m_busy = 0; m_idx = 0; m_err = 0; m_last = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_k = 1; m_err = 0;
                for (int i = 0; i < N; i++)
                    m_r[i] = use_nominal ? nom_r[i] : int'($urandom_range(1, 12));
            end else if (|stray) begin
                m_err = 1;
            end
        end else begin
            if (|stray) m_err = 1;
`ifdef LAYER_SCHEDULER_PERF_CNT_EN
            if (fin_now) m_last = 32'(m_r[layer]);
`endif
            if (ph == PH_DONE) begin
                m_busy = 0; m_idx = N - 1;
            end else begin
                m_k++;
            end
        end
    endtask

    function automatic int lit_layer(input int n);
        if (n <= 7) return 0;
        if (n <= 19) return 1;
        if (n <= 24) return 2;
        return 3;
    endfunction

    initial begin
        int done_n, done_cnt, ns;
        int seen[8];
        int offs[4];
        offs = '{0, 1024, 2048, 3072};
        for (int i = 0; i < 8; i++) seen[i] = -1;
        repeat (2) @(posedge clk);

        d_rst = 1; step(); step(); d_rst = 0; step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_offset", act_offset, 16'd0);
        chk("reset_act_cen", act_cen, 1'b1);
        chk("reset_cur_layer", cur_layer, 0);

        // nominal run, engine 1 drives a recognisable pattern
        use_nominal = 1; pin_eng1 = 1;
        d_start = 1; step(); d_start = 0;
        done_n = -1; done_cnt = 0; ns = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            for (int b = 0; b < N; b++)
                if (eng_start[b]) begin
                    if (ns < 8) seen[ns] = b;
                    ns++;
                end
            if (done) begin done_cnt++; done_n = n; end
            if (n >= 8 && n <= 18) begin
                chk("l1_act_addr0", act_addr0, 16'h0400);
                chk("l1_act_wea0", act_wea0, 4'hF);
            end
            if (n == 19) begin
                chk("gap_act_cen", act_cen, 1'b1);
                chk("gap_act_wea0", act_wea0, 4'h0);
            end
            if (n <= 34) chk("offset_literal", act_offset, offs[lit_layer(n)]);
            if (n == 20) begin
`ifdef LAYER_SCHEDULER_PERF_CNT_EN
                chk("perf_layer1", last_layer_cycles, 32'd10);
`else
                chk("perf_disabled", last_layer_cycles, 32'd0);
`endif
            end
        end
        chk("done_cycle", done_n, 34);
        chk("done_count", done_cnt, 1);
        chk("launch_count", ns, 4);
        for (int i = 0; i < 4; i++) chk("launch_order", seen[i], i);
        chk("nominal_err", protocol_err, 1'b0);
        pin_eng1 = 0;

        // stray finish from engine 3 during layer 1 RUN
        d_start = 1; step(); d_start = 0;
        for (int n = 1; n <= 38; n++) begin
            d_stray = (n == 12) ? 4'b1000 : 4'b0000;
            step();
            if (n == 11) chk("stray_before", protocol_err, 1'b0);
            if (n == 13) chk("stray_set", protocol_err, 1'b1);
            if (n == 34) begin
                chk("stray_done", done, 1'b1);
                chk("stray_sticky", protocol_err, 1'b1);
            end
        end
        d_stray = '0;

        // next start clears the error; reset during layer 2 RUN
        d_start = 1; step(); d_start = 0;
        for (int n = 1; n <= 23; n++) begin
            d_rst = (n == 22);
            step();
            if (n == 1) begin
                chk("start_clears_err", protocol_err, 1'b0);
                chk("restart_launch0", eng_start, 4'b0001);
            end
            if (n == 23) begin
                chk("rst_busy", busy, 1'b0);
                chk("rst_cur_layer", cur_layer, 0);
                chk("rst_offset", act_offset, 16'd0);
                chk("rst_eng_start", eng_start, 4'b0000);
                chk("rst_act_cen", act_cen, 1'b1);
                chk("rst_weight_cen", weight_cen, 1'b1);
            end
        end
        d_rst = 0;
        d_start = 1; step(); d_start = 0;
        step();
        chk("after_rst_launch0", eng_start, 4'b0001);
        chk("after_rst_layer0", cur_layer, 0);
        repeat (40) step();

        random_mode = 1; use_nominal = 0;
        repeat (3000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
